// File: rtl/regfile_sb_if.sv
// Operand-fetch / writeback bus of regfile_sb: read ports, write port, scoreboard mark,
// clear request and status. The register file is the slave; its client is the master.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     clr_en;
  logic                     clr_busy;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr, clr_en,
    input  rd_data, rd_busy, clr_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr, clr_en,
    output rd_data, rd_busy, clr_busy, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard, write bypass and clear sequencer.
// Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero (never written, never pending).
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]   pend;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  idx;

  logic               wr_act, mark_act, last_idx, inc, dec;
  logic [ADDR_W-1:0]  ra [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Writeback and issue are only honoured outside the clear sequence; entry 0 may be hardwired.
  assign wr_act   = bus.wr_en   && (state == IDLE) && !(ZERO_REG && bus.wr_addr   == '0);
  assign mark_act = bus.mark_en && (state == IDLE) && !(ZERO_REG && bus.mark_addr == '0);
  assign last_idx = &idx;

  // A same-entry write+mark leaves the bit set, so only a clear->set or set->clear moves the count.
  assign inc = mark_act && !pend[bus.mark_addr];
  assign dec = wr_act && pend[bus.wr_addr] && !(mark_act && bus.mark_addr == bus.wr_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_en) state_nxt = CLEAR;
      CLEAR:   if (last_idx)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the array is flop-based and reset explicitly, because reset must leave every entry zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
      cnt  <= '0;
      idx  <= '0;
    end else if (state == CLEAR) begin
      // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
      mem[idx]  <= '0;
      pend[idx] <= 1'b0;
      idx       <= idx + ADDR_W'(1);
      cnt       <= last_idx ? '0 : cnt - CNT_W'(pend[idx]);
    end else begin
      if (wr_act) begin
        mem[bus.wr_addr]  <= bus.wr_data;
        pend[bus.wr_addr] <= 1'b0;
      end
      // Placed after the write so the new producer wins on a same-entry collision.
      if (mark_act) pend[bus.mark_addr] <= 1'b1;
      cnt <= cnt + CNT_W'(inc) - CNT_W'(dec);
      if (bus.clr_en) idx <= '0;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ZERO_REG && ra[k] == '0) begin
        rd_data_c[k*DATA_W +: DATA_W] = '0;
        rd_busy_c[k]                  = 1'b0;
      end else if ((BYPASS != 0) && wr_act && bus.wr_addr == ra[k]) begin
        rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
        rd_busy_c[k]                  = mark_act && bus.mark_addr == ra[k];
      end else begin
        rd_data_c[k*DATA_W +: DATA_W] = mem[ra[k]];
        rd_busy_c[k]                  = pend[ra[k]];
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.clr_busy = (state == CLEAR);
  assign bus.pend_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus and are compared
// against an array/queue reference model of the register file and scoreboard.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             mark_en;
  logic [AW-1:0]    mark_addr;
  logic             clr_en;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

  assign bus_b.rd_addr = rd_addr;   assign bus_n.rd_addr = rd_addr;
  assign bus_b.wr_en = wr_en;       assign bus_n.wr_en = wr_en;
  assign bus_b.wr_addr = wr_addr;   assign bus_n.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;   assign bus_n.wr_data = wr_data;
  assign bus_b.mark_en = mark_en;   assign bus_n.mark_en = mark_en;
  assign bus_b.mark_addr = mark_addr; assign bus_n.mark_addr = mark_addr;
  assign bus_b.clr_en = clr_en;     assign bus_n.clr_en = clr_en;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .bus(bus_n));

  // Reference model: plain arrays plus a queue of entries still to be wiped by a clear.
  logic [DW-1:0] mem_m [DEPTH];
  bit            pend_m [DEPTH];
  int            clr_q [$];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
    if (ZERO && a == 0) return '0;
    if (byp && clr_q.size() == 0 && wr_en && int'(wr_addr) == a) return wr_data;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (ZERO && a == 0) return 1'b0;
    if (byp && clr_q.size() == 0 && wr_en && int'(wr_addr) == a)
      return mark_en && int'(mark_addr) == a;
    return pend_m[a];
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(pend_m[i]);
    return (AW+1)'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      pend_m[i] = 1'b0;
    end
    clr_q.delete();
  endtask

  // Advance one clock edge, applying the currently driven inputs to the model.
  task automatic tick();
    @(posedge clk);
    if (clr_q.size() > 0) begin
      int a;
      a = clr_q.pop_front();
      mem_m[a]  = '0;
      pend_m[a] = 1'b0;
    end else begin
      if (wr_en && !(ZERO && wr_addr == '0)) begin
        mem_m[wr_addr]  = wr_data;
        pend_m[wr_addr] = 1'b0;
      end
      if (mark_en && !(ZERO && mark_addr == '0)) pend_m[mark_addr] = 1'b1;
      if (clr_en) for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
    end
    #1;
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mark_en = 1'b0; mark_addr = '0; clr_en = 1'b0;
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr[0 +: AW]  = AW'(p0);
    rd_addr[AW +: AW] = AW'(p1);
  endtask

  task automatic fill_nonzero();
    for (int a = 1; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom() | 32'h1;
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    set_rd(0, 0);
    #12;
    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      #1;
      vectors++;
      if (bus_b.rd_data !== '0 || bus_n.rd_data !== '0) begin
        miscompares++;
        $display("FAIL reset_data addr %0d: got %h / %h want 0", a, bus_b.rd_data, bus_n.rd_data);
      end
      vectors++;
      if (bus_b.rd_busy !== '0 || bus_n.rd_busy !== '0) begin
        miscompares++;
        $display("FAIL reset_busy addr %0d: got %b / %b want 0", a, bus_b.rd_busy, bus_n.rd_busy);
      end
    end
    vectors++;
    if (bus_b.pend_cnt !== '0 || bus_b.clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: pend_cnt %0d clr_busy %b want 0 0", bus_b.pend_cnt, bus_b.clr_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    set_rd(7, 0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if (bus_b.rd_data[0 +: DW] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h want deadbeef", bus_b.rd_data[0 +: DW]);
    end
    vectors++;
    if (bus_n.rd_data[0 +: DW] !== 32'h0) begin
      miscompares++;
      $display("FAIL nobypass_same_cycle: got %h want 0", bus_n.rd_data[0 +: DW]);
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (bus_n.rd_data[0 +: DW] !== 32'hDEADBEEF || bus_b.rd_data[0 +: DW] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_next_cycle: got %h / %h want deadbeef", bus_b.rd_data[0 +: DW], bus_n.rd_data[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_mark_write();
    mark_en = 1'b1; mark_addr = 5'd3; tick();
    mark_addr = 5'd9; tick();
    drive_idle();
    set_rd(3, 9);
    @(negedge clk);
    vectors++;
    if (bus_b.pend_cnt !== 6'd2 || bus_n.pend_cnt !== 6'd2) begin
      miscompares++;
      $display("FAIL mark_cnt: got %0d / %0d want 2", bus_b.pend_cnt, bus_n.pend_cnt);
    end
    vectors++;
    if (bus_b.rd_busy !== 2'b11 || bus_n.rd_busy !== 2'b11) begin
      miscompares++;
      $display("FAIL mark_busy: got %b / %b want 11", bus_b.rd_busy, bus_n.rd_busy);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1234;
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (bus_b.pend_cnt !== 6'd1 || bus_n.pend_cnt !== 6'd1) begin
      miscompares++;
      $display("FAIL write_cnt: got %0d / %0d want 1", bus_b.pend_cnt, bus_n.pend_cnt);
    end
    vectors++;
    if (bus_b.rd_busy !== 2'b10 || bus_n.rd_busy !== 2'b10) begin
      miscompares++;
      $display("FAIL write_busy: got %b / %b want 10", bus_b.rd_busy, bus_n.rd_busy);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    set_rd(12, 12);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
    mark_en = 1'b1; mark_addr = 5'd12;
    @(negedge clk);
    vectors++;
    if (bus_b.rd_busy[0] !== 1'b1 || bus_b.rd_data[0 +: DW] !== 32'h55) begin
      miscompares++;
      $display("FAIL same_cycle_bypass: busy %b data %h want 1 55", bus_b.rd_busy[0], bus_b.rd_data[0 +: DW]);
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (bus_b.rd_data[0 +: DW] !== 32'h55 || bus_n.rd_data[0 +: DW] !== 32'h55) begin
      miscompares++;
      $display("FAIL same_cycle_data: got %h / %h want 55", bus_b.rd_data[0 +: DW], bus_n.rd_data[0 +: DW]);
    end
    vectors++;
    if (bus_b.rd_busy[0] !== 1'b1 || bus_n.pend_cnt !== 6'd2) begin
      miscompares++;
      $display("FAIL same_cycle_pend: busy %b cnt %0d want 1 2", bus_b.rd_busy[0], bus_n.pend_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow    = ($urandom_range(0, 1) == 1);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom());
      wr_data   = $urandom();
      mark_en   = ($urandom_range(0, 2) == 0);
      mark_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom());
      set_rd(($urandom_range(0, 1) == 1) ? int'(wr_addr) : int'($urandom_range(0, DEPTH - 1)),
             narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1)));
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        vectors++;
        if (bus_b.rd_data[k*DW +: DW] !== exp_data(a, 1'b1) || bus_n.rd_data[k*DW +: DW] !== exp_data(a, 1'b0)) begin
          miscompares++;
          $display("FAIL rand_data n%0d port%0d addr %0d: got %h / %h want %h / %h", n, k, a,
                   bus_b.rd_data[k*DW +: DW], bus_n.rd_data[k*DW +: DW], exp_data(a, 1'b1), exp_data(a, 1'b0));
        end
        vectors++;
        if (bus_b.rd_busy[k] !== exp_busy(a, 1'b1) || bus_n.rd_busy[k] !== exp_busy(a, 1'b0)) begin
          miscompares++;
          $display("FAIL rand_busy n%0d port%0d addr %0d: got %b / %b want %b / %b", n, k, a,
                   bus_b.rd_busy[k], bus_n.rd_busy[k], exp_busy(a, 1'b1), exp_busy(a, 1'b0));
        end
      end
      vectors++;
      if (bus_b.pend_cnt !== exp_cnt() || bus_n.pend_cnt !== exp_cnt()) begin
        miscompares++;
        $display("FAIL rand_cnt n%0d: got %0d / %0d want %0d", n, bus_b.pend_cnt, bus_n.pend_cnt, exp_cnt());
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    fill_nonzero();
    foreach (mem_m[i]) begin end
    mark_en = 1'b1;
    mark_addr = 5'd2;  tick();
    mark_addr = 5'd11; tick();
    mark_addr = 5'd17; tick();
    mark_addr = 5'd29; tick();
    drive_idle();
    clr_en = 1'b1;
    tick();
    clr_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      set_rd(int'($urandom_range(0, DEPTH - 1)), (c + 1) % DEPTH);
      if (c == 3) begin wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_0005; end
      if (c == 5) begin clr_en = 1'b1; mark_en = 1'b1; mark_addr = 5'd6; end
      @(negedge clk);
      if (bus_b.clr_busy) busy_cycles++;
      vectors++;
      if (bus_b.clr_busy !== (clr_q.size() > 0) || bus_n.clr_busy !== (clr_q.size() > 0)) begin
        miscompares++;
        $display("FAIL clr_busy c%0d: got %b / %b want %b", c, bus_b.clr_busy, bus_n.clr_busy, clr_q.size() > 0);
      end
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        vectors++;
        if (bus_b.rd_data[k*DW +: DW] !== exp_data(a, 1'b1) || bus_b.rd_busy[k] !== exp_busy(a, 1'b1)) begin
          miscompares++;
          $display("FAIL clr_read c%0d port%0d addr %0d: got %h/%b want %h/%b", c, k, a,
                   bus_b.rd_data[k*DW +: DW], bus_b.rd_busy[k], exp_data(a, 1'b1), exp_busy(a, 1'b1));
        end
      end
      tick();
      drive_idle();
    end
    vectors++;
    if (busy_cycles !== 32) begin
      miscompares++;
      $display("FAIL clr_length: got %0d cycles want 32", busy_cycles);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, 5);
      #1;
      vectors++;
      if (bus_b.rd_data !== '0 || bus_n.rd_data !== '0 || bus_b.rd_busy !== '0) begin
        miscompares++;
        $display("FAIL clr_result addr %0d: got %h / %h busy %b want 0", a, bus_b.rd_data, bus_n.rd_data, bus_b.rd_busy);
      end
    end
    vectors++;
    if (bus_b.pend_cnt !== '0 || bus_n.pend_cnt !== '0) begin
      miscompares++;
      $display("FAIL clr_cnt: got %0d / %0d want 0", bus_b.pend_cnt, bus_n.pend_cnt);
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_nonzero();
    clr_en = 1'b1;
    tick();
    clr_en = 1'b0;
    repeat (10) tick();
    set_rd(20, 31);
    #1;
    vectors++;
    if (bus_b.rd_data[0 +: DW] !== exp_data(20, 1'b1) || bus_b.rd_data[DW +: DW] !== exp_data(31, 1'b1)
        || exp_data(20, 1'b1) == '0) begin
      miscompares++;
      $display("FAIL midclr_before: got %h %h want %h %h (nonzero)", bus_b.rd_data[0 +: DW],
               bus_b.rd_data[DW +: DW], exp_data(20, 1'b1), exp_data(31, 1'b1));
    end
    reset = 1'b1;
    #1;
    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      #1;
      vectors++;
      if (bus_b.rd_data !== '0 || bus_n.rd_data !== '0 || bus_b.clr_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midclr_reset addr %0d: got %h / %h clr_busy %b want 0", a, bus_b.rd_data, bus_n.rd_data, bus_b.clr_busy);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus_b.clr_busy !== 1'b0 || bus_b.pend_cnt !== '0) begin
      miscompares++;
      $display("FAIL midclr_resume: clr_busy %b cnt %0d want 0 0", bus_b.clr_busy, bus_b.pend_cnt);
    end
    set_rd(0, 0);
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1;
    mark_en = 1'b1; mark_addr = '0;
    @(negedge clk);
    vectors++;
    if (bus_b.rd_data[0 +: DW] !== exp_data(0, 1'b1) || bus_b.rd_busy[0] !== exp_busy(0, 1'b1)) begin
      miscompares++;
      $display("FAIL zero_reg_bypass: got %h/%b want %h/%b", bus_b.rd_data[0 +: DW], bus_b.rd_busy[0],
               exp_data(0, 1'b1), exp_busy(0, 1'b1));
    end
    tick();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (bus_b.rd_data[0 +: DW] !== exp_data(0, 1'b1) || bus_n.rd_data[0 +: DW] !== exp_data(0, 1'b0)
        || bus_b.pend_cnt !== exp_cnt()) begin
      miscompares++;
      $display("FAIL zero_reg_write: got %h / %h cnt %0d want %h cnt %0d", bus_b.rd_data[0 +: DW],
               bus_n.rd_data[0 +: DW], bus_b.pend_cnt, exp_data(0, 1'b0), exp_cnt());
    end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    rd_addr = '0;
    model_reset();
    test_reset();
    test_bypass();
    test_mark_write();
    test_same_cycle();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
